gng_stats_monitor: RTL

Receive-side statistics monitor for the Gaussian noise path. Consumes the scaled noise stream (s<32,22> samples with valid) and, on a start command, accumulates exactly 2^LOG2_N_SAMPLES valid samples. It then reports the sample mean, the mean power and the variance. It sits downstream of the noise generator/channel and is used to check that the delivered sigma matches the programmed sigma multiplier.

---
 rtl/gng_stats_monitor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/gng_stats_monitor.sv
`default_nettype none
// ============================================================================
// Module   : gng_stats_monitor
// Purpose  : Accumulates 2^LOG2_N_SAMPLES noise samples and reports their
//            mean, mean power and variance.
// Revision : 1.0 - initial release
// ============================================================================
module gng_stats_monitor #(
    parameter int NB_DATA        = 32,
    parameter int NB_FRAC        = 22,
    parameter int LOG2_N_SAMPLES = 10
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic signed [NB_DATA-1:0]   i_data,
    input  logic                        i_valid,
    input  logic                        i_start,
    output logic                        o_busy,
    output logic                        o_done,
    output logic signed [NB_DATA-1:0]   o_mean,
    output logic [2*NB_DATA-1:0]        o_power,
    output logic [2*NB_DATA-1:0]        o_variance
);

    localparam int C_NB_SUM   = NB_DATA + LOG2_N_SAMPLES;
    localparam int C_NB_SUMSQ = 2*NB_DATA + LOG2_N_SAMPLES;

    if (LOG2_N_SAMPLES < 1 || LOG2_N_SAMPLES > 16 || NB_FRAC < 0 || NB_FRAC >= NB_DATA) begin : g_param_check
        $error("gng_stats_monitor: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_CALC  = 2'd2,
        S_VAR   = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [LOG2_N_SAMPLES-1:0]      r_count;
    logic signed [C_NB_SUM-1:0]     r_sum;
    logic [C_NB_SUMSQ-1:0]          r_sumsq;
    logic signed [NB_DATA-1:0]      r_mean;
    logic [2*NB_DATA-1:0]           r_power;
    logic [2*NB_DATA-1:0]           r_variance;
    logic                           r_busy;
    logic                           r_done;

    logic [2*NB_DATA-1:0]           w_data_sq;
    logic [2*NB_DATA-1:0]           w_mean_sq;
    logic                           w_last;

    // Signed products are never negative, so they fit the unsigned width.
    assign w_data_sq = i_data * i_data;
    assign w_mean_sq = r_mean * r_mean;
    assign w_last    = i_valid && (r_count == {LOG2_N_SAMPLES{1'b1}});

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_ACCUM;
            S_ACCUM: if (w_last)  w_state_next = S_CALC;
            S_CALC:  w_state_next = S_VAR;
            S_VAR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count    <= '0;
            r_sum      <= '0;
            r_sumsq    <= '0;
            r_mean     <= '0;
            r_power    <= '0;
            r_variance <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (r_state == S_VAR);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_count <= '0;
                        r_sum   <= '0;
                        r_sumsq <= '0;
                    end
                end
                S_ACCUM: begin
                    if (i_valid) begin
                        r_count <= r_count + 1'b1;
                        r_sum   <= r_sum + {{LOG2_N_SAMPLES{i_data[NB_DATA-1]}}, i_data};
                        r_sumsq <= r_sumsq + {{LOG2_N_SAMPLES{1'b0}}, w_data_sq};
                    end
                end
                S_CALC: begin
                    // Taking the upper slice is the floor shift by LOG2_N_SAMPLES.
                    r_mean  <= r_sum[C_NB_SUM-1:LOG2_N_SAMPLES];
                    r_power <= r_sumsq[C_NB_SUMSQ-1:LOG2_N_SAMPLES];
                end
                S_VAR: begin
                    if (w_mean_sq > r_power) begin
                        r_variance <= '0;
                    end else begin
                        r_variance <= r_power - w_mean_sq;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_mean     = r_mean;
    assign o_power    = r_power;
    assign o_variance = r_variance;

endmodule
`default_nettype wire
